// File: rtl/mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_arbiter_pkg
// Description : Shared state encoding and select-line values for the 2:1 mux
//               select arbiter and its hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sel_arbiter_pkg;

  typedef logic [1:0] state_t;

  // FSM state encoding
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_OWN_A = 2'd1;
  localparam state_t ST_OWN_B = 2'd2;

  // Mux select values
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_sel_arbiter_pkg
`default_nettype wire

// File: rtl/mux_sel_arbiter_hold_counter.sv
`default_nettype none
// ============================================================================
// Module      : hold_counter
// Description : Counts the cycles of the current grant and flags the last
//               permitted cycle (count == HOLD_MAX-1).
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               clr_i    - clear count to zero (takes priority over en_i)
//               en_i     - advance count by one this cycle
//               expire_o - count has reached HOLD_MAX-1
// Revision    : 1.0 - initial release
// ============================================================================
module hold_counter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] count_q;

  assign expire_o = (count_q == C_LAST);

  // Stop at the expiry value: the arbiter always leaves the grant on that
  // cycle, so holding here only guards against a wrap if en_i were misused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expire_o) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule : hold_counter
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Round-robin arbiter for two requesters driving the select
//               line of a 2:1 data mux. Grants are bounded to HOLD_MAX
//               cycles; all outputs are registered.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-high reset
//               req_a   - requester A wants the mux (level)
//               req_b   - requester B wants the mux (level)
//               rel     - current owner releases the mux
//               sel     - mux select (0 = A, 1 = B)
//               gnt_a   - A owns the mux
//               gnt_b   - B owns the mux
//               busy    - either grant active
//               timeout - one-cycle pulse after a grant ended purely by expiry
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic rel,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy,
  output logic timeout
);

  state_t state_q, state_d;
  logic   last_b_q, last_b_d;   // 1 = B was the most recently served owner
  logic   sel_q, sel_d;
  logic   gnt_a_q, gnt_a_d;
  logic   gnt_b_q, gnt_b_d;
  logic   busy_q, busy_d;
  logic   timeout_q, timeout_d;

  logic   expire;
  logic   cnt_clr;
  logic   cnt_en;

  // The counter restarts on every state change, so it reads zero on the
  // first cycle of each new grant, including a direct A<->B hand-over.
  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q != ST_IDLE);

  hold_counter #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_o (expire)
  );

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_b_q  <= 1'b1;        // A wins the first tie
      sel_q     <= SEL_A;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      sel_q     <= sel_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and round-robin pointer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? ST_OWN_A : ST_OWN_B;
        end else if (req_a) begin
          state_d = ST_OWN_A;
        end else if (req_b) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (rel || !req_a || expire) begin
          state_d  = req_b ? ST_OWN_B : ST_IDLE;
          last_b_d = 1'b0;
        end
      end
      ST_OWN_B: begin
        if (rel || !req_b || expire) begin
          state_d  = req_a ? ST_OWN_A : ST_IDLE;
          last_b_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (registered next edge, so derived from state_d)
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_a_d   = (state_d == ST_OWN_A);
    gnt_b_d   = (state_d == ST_OWN_B);
    busy_d    = (state_d != ST_IDLE);
    sel_d     = sel_q;          // IDLE keeps the last select
    timeout_d = 1'b0;
    if (state_d == ST_OWN_A) begin
      sel_d = SEL_A;
    end else if (state_d == ST_OWN_B) begin
      sel_d = SEL_B;
    end
    // Only a pure expiry reports a timeout: a release or a dropped request
    // on the same cycle means the owner was finishing anyway.
    if (expire && !rel) begin
      if ((state_q == ST_OWN_A && req_a) || (state_q == ST_OWN_B && req_b)) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign sel     = sel_q;
  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule : mux_sel_arbiter
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Self-checking bench for mux_sel_arbiter. Vector table of
//               {req_a, req_b, rel, expected outputs}; expected output words
//               are {sel, gnt_a, gnt_b, busy, timeout}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

  localparam int HOLD_MAX = 15;

  // Expected output words {sel, gnt_a, gnt_b, busy, timeout}
  localparam logic [4:0] E_I0    = 5'b00000;
  localparam logic [4:0] E_I1    = 5'b10000;
  localparam logic [4:0] E_I1_TO = 5'b10001;
  localparam logic [4:0] E_A     = 5'b01010;
  localparam logic [4:0] E_A_TO  = 5'b01011;
  localparam logic [4:0] E_B     = 5'b10110;

  typedef struct packed {
    logic       req_a;
    logic       req_b;
    logic       rel;
    logic [4:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic rel   = 1'b0;
  logic sel, gnt_a, gnt_b, busy, timeout;

  vec_t       vecs[$];
  logic [4:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  mux_sel_arbiter #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .rel     (rel),
    .sel     (sel),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic a, input logic b, input logic r,
                              input logic [4:0] e);
    vec_t v;
    v.req_a = a;
    v.req_b = b;
    v.rel   = r;
    v.exp   = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [4:0] act,
                       input logic [4:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got {sel,ga,gb,busy,to}=%b expected %b at %0t",
               name, act, req, $time);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string name);
    logic [4:0] e;
    req_a = v.req_a;
    req_b = v.req_b;
    rel   = v.rel;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, {sel, gnt_a, gnt_b, busy, timeout}, e);
    end
  endtask

  // Invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ((gnt_a && gnt_b) || (busy !== (gnt_a | gnt_b)) ||
          (gnt_b && sel !== 1'b1) || (gnt_a && sel !== 1'b0)) begin
        n_bad++;
        $display("FAIL invariant: got ga=%b gb=%b busy=%b sel=%b expected exclusive grants, busy=ga|gb, sel matching owner",
                 gnt_a, gnt_b, busy, sel);
      end
    end
  end

  initial begin
    vec_t v;

    // Single request, release, re-grant after one idle cycle
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, E_A);
    add(1'b1, 1'b0, 1'b1, E_I0);
    add(1'b1, 1'b0, 1'b0, E_A);
    add(1'b0, 1'b0, 1'b0, E_I0);
    // Round-robin with rel every 3rd cycle (A served last -> B first)
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b1, 1'b0, (k % 2 == 0) ? E_B : E_A);
      add(1'b1, 1'b1, 1'b0, (k % 2 == 0) ? E_B : E_A);
      add(1'b1, 1'b1, 1'b1, (k % 2 == 0) ? E_A : E_B);
    end
    add(1'b0, 1'b0, 1'b0, E_I0);
    // Timeout on B alone: 15 granted cycles, then pulse with sel held at 1
    for (int i = 0; i < HOLD_MAX; i++) add(1'b0, 1'b1, 1'b0, E_B);
    add(1'b0, 1'b1, 1'b0, E_I1_TO);
    add(1'b0, 1'b0, 1'b0, E_I1);
    // Timeout on B while A waits: direct hand-over with the pulse
    add(1'b0, 1'b1, 1'b0, E_B);
    for (int i = 1; i < HOLD_MAX; i++) add(1'b1, 1'b1, 1'b0, E_B);
    add(1'b1, 1'b1, 1'b0, E_A_TO);
    add(1'b0, 1'b0, 1'b0, E_I0);
    // rel on the expiry cycle: no timeout
    for (int i = 0; i < HOLD_MAX; i++) add(1'b1, 1'b0, 1'b0, E_A);
    add(1'b1, 1'b0, 1'b1, E_I0);
    add(1'b0, 1'b0, 1'b0, E_I0);
    // req_a dropped mid-grant
    add(1'b1, 1'b0, 1'b0, E_A);
    add(1'b1, 1'b0, 1'b0, E_A);
    add(1'b0, 1'b0, 1'b0, E_I0);
    // req_a dropped on the expiry cycle: no timeout
    for (int i = 0; i < HOLD_MAX; i++) add(1'b1, 1'b0, 1'b0, E_A);
    add(1'b0, 1'b0, 1'b0, E_I0);

    // Reset state
    #1;
    check("reset_state", {sel, gnt_a, gnt_b, busy, timeout}, E_I0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a B grant
    v.req_a = 1'b0; v.req_b = 1'b1; v.rel = 1'b0; v.exp = E_B;
    apply(v, "pre_reset_own_b");
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_mid_grant", {sel, gnt_a, gnt_b, busy, timeout}, E_I0);
    req_a = 1'b1;
    req_b = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    v.req_a = 1'b1; v.req_b = 1'b1; v.rel = 1'b0; v.exp = E_A;
    apply(v, "tie_after_reset_a_first");
    v.req_a = 1'b0; v.req_b = 1'b0; v.rel = 1'b0; v.exp = E_I0;
    apply(v, "idle_after_reset_test");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_sel_arbiter
`default_nettype wire
